conv_bram_arbiter: RTL
======================

# conv_bram_arbiter

Single-port BRAM arbiter placed between the convolution RAM controller and the host-side AXI register/memory bridge. It shares one BRAM port, 1-cycle read latency, between three requesters:
- conv read stream (weights and input pixels);
- conv result writes, posted through an internal write FIFO;
- host single-beat reads and writes.

Conv reads are never stalled. Result writes drain in conv-read gaps. The host is served only when conv traffic and the FIFO are idle.

## Interface
- ADDR_BW, 12, BRAM word address width
- DATA_BW, 16, BRAM data width
- WFIFO_DEPTH, 8, write FIFO entries (power of two, ≥2)
- WFIFO_PTR_BW, 3, log2(WFIFO_DEPTH)

- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- c_r_en, c_r_addr  in  1, ADDR_BW  conv read request and address
- c_r_data  out  DATA_BW  conv read data (= m_rdata, combinational)
- c_w_en, c_w_addr, c_w_data  in  1, ADDR_BW, DATA_BW  conv posted write
- h_req, h_we  in  1, 1  host request, held until h_ack; write/read select
- h_addr, h_wdata  in  ADDR_BW, DATA_BW  host address and write data
- h_ack  out  1  one-cycle completion pulse
- h_rdata  out  DATA_BW  host read data, valid with h_ack
- m_en, m_we  out  1, 1  BRAM port enable and write enable
- m_addr, m_wdata  out  ADDR_BW, DATA_BW  BRAM port address and write data
- m_rdata  in  DATA_BW  BRAM read data, valid the cycle after m_en & !m_we
- o_wfifo_level  out  WFIFO_PTR_BW+1  FIFO occupancy
- o_wfifo_empty  out  1  FIFO empty; conv DONE uses it to know results are flushed
- o_overflow  out  1  sticky: a conv write was dropped
- i_clr_err  in  1  clears o_overflow

## Operation
- Port select is combinational each cycle, strict priority:
  1. c_r_en=1: m_en=1, m_we=0, m_addr=c_r_addr.
  2. Else FIFO non-empty: pop the head entry and write it (m_en=1, m_we=1).
  3. Else host FSM is H_IDLE and h_req=1: grant the host (m_en=1, m_we=h_we, h_addr, h_wdata).
  4. Else m_en=0, m_we=0. Idle values: m_addr=0, m_wdata=0.
- Write FIFO:
  - c_w_en pushes {c_w_addr, c_w_data}.
  - Push and pop may occur in the same cycle. This is allowed when full, and level is unchanged.
  - Push when full with no pop: the entry is dropped, o_overflow is set, and FIFO contents are unchanged.
  - No bypass: a write reaches BRAM no earlier than the cycle after its push. FIFO order is preserved.
- Host FSM:
  - H_IDLE: on grant go to H_DATA.
  - H_DATA: capture h_rdata<=m_rdata (reads only; writes leave h_rdata unchanged), set h_ack<=1, go to H_ACK.
  - H_ACK: h_ack=1 for this cycle only. h_req is ignored in this cycle. Go to H_IDLE.
  - The requester must drop h_req, or present the next request, by the cycle after h_ack.
  - The port is free for conv traffic during H_DATA and H_ACK.
- Hazards: no read-after-write check is performed. Conv reads and result writes target disjoint regions; software must not host-read results before o_wfifo_empty=1.
- Starvation: continuous c_r_en starves both FIFO drain and the host. This is intended. Conv issues read gaps between kernel passes, and the FIFO is sized to cover one pass.
- o_overflow: cleared by i_clr_err. If set and clear happen in the same cycle, set wins.

## Timing
- Reset values:
  - FIFO empty, o_wfifo_level=0, o_wfifo_empty=1.
  - o_overflow=0, h_ack=0, h_rdata=0, host FSM in H_IDLE.
  - m_en=0 and m_we=0 are forced while ARESETn=0.
- Reset mid-operation discards FIFO contents and any pending host access. No BRAM write is issued during or after reset for pre-reset requests.
- Conv read: address in cycle T, c_r_data valid in T+1. This is zero added latency.
- Host read or write: grant in T, h_ack/h_rdata in T+2. The next grant is possible at T+3 at the earliest.
- FIFO level updates at the clock edge after the push/pop. o_wfifo_empty is registered and consistent with the level.

## Test plan
- Host write 0x00A5 to addr 5 (conv idle), then host read addr 5 → m_we pulse at T; h_ack at T+2; read returns h_rdata=0x00A5 with h_ack.
- c_r_en held for 10 cycles, addrs 160..169, with h_req asserted throughout → c_r_data follows memory one cycle later with no bubbles; host granted the cycle after c_r_en drops; h_ack two cycles later.
- 3 conv writes to 1280/1282/1284 during a continuous read burst → level reaches 3, no m_we; after the burst, three consecutive m_we in push order; o_wfifo_empty=1 afterwards.
- 9 pushes during a read burst with WFIFO_DEPTH=8 → 9th dropped, o_overflow=1, level=8; i_clr_err clears the flag; the drained 8 entries match pushes 1–8.
- Push with full FIFO in a pop cycle → no overflow, level stays 8.
- Assert ARESETn=0 with 4 entries queued and a host read in H_DATA → after release: level 0, h_ack never pulses, no stale m_we.

Source files
------------

// File: rtl/conv_bram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : conv_bram_arbiter
//  Purpose  : Shares one single-port BRAM (1-cycle read latency) between the
//             conv read stream, posted conv result writes (via an internal
//             write FIFO) and single-beat host accesses. Strict priority:
//             conv read > FIFO drain > host.
//  Revision : 1.0  initial release
// ============================================================================
module conv_bram_arbiter #(
   parameter int ADDR_BW      = 12,
   parameter int DATA_BW      = 16,
   parameter int WFIFO_DEPTH  = 8,
   parameter int WFIFO_PTR_BW = 3
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   // conv read stream
   input  logic                    c_r_en,
   input  logic [ADDR_BW-1:0]      c_r_addr,
   output logic [DATA_BW-1:0]      c_r_data,
   // conv posted writes
   input  logic                    c_w_en,
   input  logic [ADDR_BW-1:0]      c_w_addr,
   input  logic [DATA_BW-1:0]      c_w_data,
   // host single-beat access
   input  logic                    h_req,
   input  logic                    h_we,
   input  logic [ADDR_BW-1:0]      h_addr,
   input  logic [DATA_BW-1:0]      h_wdata,
   output logic                    h_ack,
   output logic [DATA_BW-1:0]      h_rdata,
   // BRAM port
   output logic                    m_en,
   output logic                    m_we,
   output logic [ADDR_BW-1:0]      m_addr,
   output logic [DATA_BW-1:0]      m_wdata,
   input  logic [DATA_BW-1:0]      m_rdata,
   // status
   output logic [WFIFO_PTR_BW:0]   o_wfifo_level,
   output logic                    o_wfifo_empty,
   output logic                    o_overflow,
   input  logic                    i_clr_err
);

   localparam int                    ENTRY_BW = ADDR_BW + DATA_BW;
   localparam logic [WFIFO_PTR_BW:0] C_DEPTH  = (WFIFO_PTR_BW+1)'(WFIFO_DEPTH);

   // host FSM encoding
   localparam logic [1:0] H_IDLE = 2'd0;
   localparam logic [1:0] H_DATA = 2'd1;
   localparam logic [1:0] H_ACK  = 2'd2;

   // write FIFO storage and bookkeeping
   logic [ENTRY_BW-1:0]     fifo_mem_q [WFIFO_DEPTH];
   logic [ENTRY_BW-1:0]     fifo_mem_d [WFIFO_DEPTH];
   logic [WFIFO_PTR_BW-1:0] wr_ptr_q, wr_ptr_d;
   logic [WFIFO_PTR_BW-1:0] rd_ptr_q, rd_ptr_d;
   logic [WFIFO_PTR_BW:0]   level_q, level_d;
   logic                    empty_q, empty_d;
   logic                    overflow_q, overflow_d;

   // host side state
   logic [1:0]              h_state_q, h_state_d;
   logic                    h_we_q, h_we_d;       // direction of the access in flight
   logic                    h_ack_q, h_ack_d;
   logic [DATA_BW-1:0]      h_rdata_q, h_rdata_d;

   // port select results
   logic                    port_en;
   logic                    port_we;
   logic [ADDR_BW-1:0]      port_addr;
   logic [DATA_BW-1:0]      port_wdata;
   logic                    fifo_pop;
   logic                    host_grant;
   logic                    fifo_full;
   logic                    fifo_push_ok;

   // Strict-priority port select; the FIFO head is only visible once the
   // registered empty flag clears, so a push never bypasses to the port.
   always_comb begin
      port_en    = 1'b0;
      port_we    = 1'b0;
      port_addr  = '0;
      port_wdata = '0;
      fifo_pop   = 1'b0;
      host_grant = 1'b0;
      if (c_r_en) begin
         port_en   = 1'b1;
         port_addr = c_r_addr;
      end else if (!empty_q) begin
         port_en                 = 1'b1;
         port_we                 = 1'b1;
         {port_addr, port_wdata} = fifo_mem_q[rd_ptr_q];
         fifo_pop                = 1'b1;
      end else if ((h_state_q == H_IDLE) && h_req) begin
         port_en    = 1'b1;
         port_we    = h_we;
         port_addr  = h_addr;
         port_wdata = h_wdata;
         host_grant = 1'b1;
      end
   end

   // Enables are gated by reset so nothing reaches the BRAM while in reset.
   assign m_en     = port_en & ARESETn;
   assign m_we     = port_we & ARESETn;
   assign m_addr   = port_addr;
   assign m_wdata  = port_wdata;
   assign c_r_data = m_rdata;

   // Write FIFO next state: a push into a full FIFO survives only if the
   // head is popped in the same cycle; otherwise it is dropped and flagged.
   always_comb begin
      fifo_full    = (level_q == C_DEPTH);
      fifo_push_ok = c_w_en & (~fifo_full | fifo_pop);
      fifo_mem_d   = fifo_mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      if (fifo_push_ok) begin
         fifo_mem_d[wr_ptr_q] = {c_w_addr, c_w_data};
         wr_ptr_d             = wr_ptr_q + WFIFO_PTR_BW'(1);
      end
      if (fifo_pop) begin
         rd_ptr_d = rd_ptr_q + WFIFO_PTR_BW'(1);
      end
      case ({fifo_push_ok, fifo_pop})
         2'b10:   level_d = level_q + (WFIFO_PTR_BW+1)'(1);
         2'b01:   level_d = level_q - (WFIFO_PTR_BW+1)'(1);
         default: level_d = level_q;
      endcase
      empty_d = (level_d == '0);
      // set has priority over clear
      if (c_w_en && fifo_full && !fifo_pop) begin
         overflow_d = 1'b1;
      end else if (i_clr_err) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Host FSM next-state: one grant cycle, one data-capture cycle, one ack cycle.
   always_comb begin
      h_state_d = h_state_q;
      case (h_state_q)
         H_IDLE:  if (host_grant) h_state_d = H_DATA;
         H_DATA:  h_state_d = H_ACK;
         H_ACK:   h_state_d = H_IDLE;
         default: h_state_d = H_IDLE;
      endcase
   end

   // Host FSM outputs: capture read data in H_DATA and raise ack for H_ACK.
   always_comb begin
      h_we_d    = host_grant ? h_we : h_we_q;
      h_ack_d   = (h_state_q == H_DATA);
      h_rdata_d = h_rdata_q;
      if ((h_state_q == H_DATA) && !h_we_q) begin
         h_rdata_d = m_rdata;
      end
   end

   // Control and status registers, cleared asynchronously.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         h_state_q  <= H_IDLE;
         h_we_q     <= 1'b0;
         h_ack_q    <= 1'b0;
         h_rdata_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         h_state_q  <= h_state_d;
         h_we_q     <= h_we_d;
         h_ack_q    <= h_ack_d;
         h_rdata_q  <= h_rdata_d;
      end
   end

   // FIFO payload storage needs no reset; the pointers define validity.
   always_ff @(posedge ACLK) begin
      fifo_mem_q <= fifo_mem_d;
   end

   assign h_ack         = h_ack_q;
   assign h_rdata       = h_rdata_q;
   assign o_wfifo_level = level_q;
   assign o_wfifo_empty = empty_q;
   assign o_overflow    = overflow_q;

endmodule
`default_nettype wire
